// File: rtl/mux_nx1_scan_pkg.sv
// Shared types and constants for the N:1 scanning channel multiplexer.
package mux_nx1_scan_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of the dwell counter; stays at least one bit when DWELL is 1.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Channel bus between the sample source/consumer and mux_nx1_scan.
// ch_mask exists only when CH_MASK_EN is defined.
interface mux_nx1_scan_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int SELW = $clog2(N);

    logic            mode;
    logic            en;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  in_bus;
    logic [W-1:0]    y;
    logic            y_valid;
    logic [SELW-1:0] cur_sel;
    logic            wrap;
`ifdef CH_MASK_EN
    logic [N-1:0]    ch_mask;
`endif

    modport master (
`ifdef CH_MASK_EN
        output ch_mask,
`endif
        output mode, en, sel, in_bus,
        input  y, y_valid, cur_sel, wrap
    );

    modport slave (
`ifdef CH_MASK_EN
        input  ch_mask,
`endif
        input  mode, en, sel, in_bus,
        output y, y_valid, cur_sel, wrap
    );

endinterface

// File: rtl/mux_nx1_scan_mux.sv
// Purely combinational W-bit N:1 selector; an out-of-range index yields 0.
module mux_nx1 #(
    parameter int N = 8,
    parameter int W = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic [N*W-1:0]  in_bus_i,
    input  logic [SELW-1:0] sel_i,
    output logic [W-1:0]    y_o
);

    always_comb begin
        y_o = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_i == SELW'(k)) y_o = in_bus_i[k*W +: W];
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1 W-bit registered channel mux with direct select or round-robin scan with dwell.
// Optional per-channel enable mask when CH_MASK_EN is defined.
module mux_nx1_scan
    import mux_nx1_scan_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int DWELL = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_scan_if.slave mux_if
);

    localparam int SELW = $clog2(N);
    localparam int DCW  = dwell_cnt_w(DWELL);

    state_t          state_q, state_d;
    logic [W-1:0]    y_q, y_d;
    logic            y_valid_q, y_valid_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic            wrap_q, wrap_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [DCW-1:0]  dwell_q, dwell_d;

    logic [N-1:0]    eff_mask;
    logic [SELW-1:0] mux_idx;
    logic [W-1:0]    mux_y;
    logic            sel_ok, ptr_ok, above_found, last_dwell;
    logic [SELW-1:0] above_idx, low_idx, next_ptr;

`ifdef CH_MASK_EN
    assign eff_mask = mux_if.ch_mask;
`else
    assign eff_mask = '1;
`endif

    assign mux_idx = (mux_if.mode == MODE_SCAN) ? ptr_q : mux_if.sel;

    mux_nx1 #(.N(N), .W(W)) u_mux (
        .in_bus_i (mux_if.in_bus),
        .sel_i    (mux_idx),
        .y_o      (mux_y)
    );

    // Next enabled channel above ptr, else the lowest enabled one (wrap-around).
    always_comb begin
        sel_ok      = 1'b0;
        ptr_ok      = 1'b0;
        above_found = 1'b0;
        above_idx   = ptr_q;
        low_idx     = ptr_q;
        for (int k = N - 1; k >= 0; k--) begin
            if (mux_if.sel == SELW'(k)) sel_ok = eff_mask[k];
            if (ptr_q == SELW'(k))      ptr_ok = eff_mask[k];
            if (eff_mask[k]) begin
                low_idx = SELW'(k);
                if (SELW'(k) > ptr_q) begin
                    above_found = 1'b1;
                    above_idx   = SELW'(k);
                end
            end
        end
    end

    assign next_ptr   = above_found ? above_idx : low_idx;
    assign last_dwell = (dwell_q == DCW'(DWELL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (mux_if.en && mux_if.mode == MODE_SCAN) ? ST_SCAN : ST_IDLE;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        y_d       = y_q;
        cur_sel_d = cur_sel_q;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;
        ptr_d     = ptr_q;
        dwell_d   = dwell_q;

        if (mux_if.mode == MODE_DIRECT) begin
            ptr_d   = '0;
            dwell_d = '0;
            if (mux_if.en && sel_ok) begin
                y_d       = mux_y;
                cur_sel_d = mux_if.sel;
                y_valid_d = 1'b1;
            end
        end else if (state_d == ST_SCAN && |eff_mask) begin
            if (!ptr_ok) begin
                // Current channel was masked off: skip ahead without producing a sample.
                ptr_d   = next_ptr;
                dwell_d = '0;
            end else begin
                y_d       = mux_y;
                cur_sel_d = ptr_q;
                y_valid_d = 1'b1;
                if (last_dwell) begin
                    dwell_d = '0;
                    ptr_d   = next_ptr;
                    wrap_d  = !above_found;
                end else begin
                    dwell_d = dwell_q + DCW'(1);
                end
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
            ptr_q     <= '0;
            dwell_q   <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
            ptr_q     <= ptr_d;
            dwell_q   <= dwell_d;
        end
    end

    assign mux_if.y       = y_q;
    assign mux_if.y_valid = y_valid_q;
    assign mux_if.cur_sel = cur_sel_q;
    assign mux_if.wrap    = wrap_q;

    wrap_only_in_scan: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_IDLE) |-> !wrap_q);

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: N=8/W=4/DWELL=2 plus an N=6 instance for out-of-range select.
module tb_mux_nx1_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_nx1_scan_if #(.N(8), .W(4)) bus8 ();
    mux_nx1_scan_if #(.N(6), .W(4)) bus6 ();

    mux_nx1_scan #(.N(8), .W(4), .DWELL(2)) dut8 (.clk(clk), .rst(rst), .mux_if(bus8));
    mux_nx1_scan #(.N(6), .W(4), .DWELL(2)) dut6 (.clk(clk), .rst(rst), .mux_if(bus6));

    logic [3:0] exp_y;
    logic [2:0] exp_sel;
    logic       exp_wrap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_initial();
        #2;
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_init: got y=%h v=%b sel=%0d wrap=%b required all zero",
                     bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_direct();
        bus8.en = 1'b1; bus8.mode = 1'b0; bus8.sel = 3'd5;
        bus6.en = 1'b1; bus6.mode = 1'b0; bus6.sel = 3'd5;
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {4'h6, 1'b1, 3'd5}) begin
            n_fail++;
            $display("FAIL direct_sel5: got y=%h v=%b sel=%0d required y=6 v=1 sel=5",
                     bus8.y, bus8.y_valid, bus8.cur_sel);
        end
        n_run++;
        if ({bus6.y, bus6.y_valid, bus6.cur_sel} !== {4'h6, 1'b1, 3'd5}) begin
            n_fail++;
            $display("FAIL direct6_sel5: got y=%h v=%b sel=%0d required y=6 v=1 sel=5",
                     bus6.y, bus6.y_valid, bus6.cur_sel);
        end
        bus8.sel = 3'd7; bus6.sel = 3'd7;
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {4'h8, 1'b1, 3'd7}) begin
            n_fail++;
            $display("FAIL direct_sel7: got y=%h v=%b sel=%0d required y=8 v=1 sel=7",
                     bus8.y, bus8.y_valid, bus8.cur_sel);
        end
        n_run++;
        if ({bus6.y, bus6.y_valid, bus6.cur_sel} !== {4'h6, 1'b0, 3'd5}) begin
            n_fail++;
            $display("FAIL direct6_out_of_range: got y=%h v=%b sel=%0d required y=6 v=0 sel=5",
                     bus6.y, bus6.y_valid, bus6.cur_sel);
        end
        bus8.sel = 3'd0;
        bus6.en  = 1'b0;
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {4'h1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL direct_sel0: got y=%h v=%b sel=%0d required y=1 v=1 sel=0",
                     bus8.y, bus8.y_valid, bus8.cur_sel);
        end
        bus8.en = 1'b0; bus8.sel = 3'd3;
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {4'h1, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL direct_paused: got y=%h v=%b sel=%0d required y=1 v=0 sel=0",
                     bus8.y, bus8.y_valid, bus8.cur_sel);
        end
        bus8.en = 1'b1;
    endtask

    task automatic test_scan();
        bus8.mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_sel  = 3'((i / 2) % 8);
            exp_y    = 4'(exp_sel) + 4'd1;
            exp_wrap = (i == 15);
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {exp_y, 1'b1, exp_sel, exp_wrap}) begin
                n_fail++;
                $display("FAIL scan_step%0d: got y=%h v=%b sel=%0d wrap=%b required y=%h v=1 sel=%0d wrap=%b",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap, exp_y, exp_sel, exp_wrap);
            end
        end
    endtask

    task automatic test_pause();
        bus8.mode = 1'b0;
        tick();
        bus8.mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_sel = 3'(i / 2);
            exp_y   = 4'(exp_sel) + 4'd1;
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {exp_y, 1'b1, exp_sel, 1'b0}) begin
                n_fail++;
                $display("FAIL pause_lead%0d: got y=%h v=%b sel=%0d wrap=%b required y=%h v=1 sel=%0d wrap=0",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap, exp_y, exp_sel);
            end
        end
        bus8.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {4'h4, 1'b0, 3'd3, 1'b0}) begin
                n_fail++;
                $display("FAIL pause_hold%0d: got y=%h v=%b sel=%0d wrap=%b required y=4 v=0 sel=3 wrap=0",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
            end
        end
        bus8.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_sel = (i == 0) ? 3'd3 : 3'd4;
            exp_y   = 4'(exp_sel) + 4'd1;
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {exp_y, 1'b1, exp_sel}) begin
                n_fail++;
                $display("FAIL pause_resume%0d: got y=%h v=%b sel=%0d required y=%h v=1 sel=%0d",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, exp_y, exp_sel);
            end
        end
    endtask

    task automatic test_mode_switch();
        bus8.mode = 1'b0; bus8.sel = 3'd2;
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {4'h3, 1'b1, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL switch_direct: got y=%h v=%b sel=%0d wrap=%b required y=3 v=1 sel=2 wrap=0",
                     bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
        end
        bus8.mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_sel = 3'(i / 2);
            exp_y   = 4'(exp_sel) + 4'd1;
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {exp_y, 1'b1, exp_sel}) begin
                n_fail++;
                $display("FAIL switch_rescan%0d: got y=%h v=%b sel=%0d required y=%h v=1 sel=%0d",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, exp_y, exp_sel);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        #3;
        rst = 1'b1;
        #1;
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_async: got y=%h v=%b sel=%0d wrap=%b required all zero",
                     bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
        end
        tick();
        n_run++;
        if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_held: got y=%h v=%b sel=%0d wrap=%b required all zero",
                     bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_sel = 3'(i / 2);
            exp_y   = 4'(exp_sel) + 4'd1;
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel} !== {exp_y, 1'b1, exp_sel}) begin
                n_fail++;
                $display("FAIL reset_restart%0d: got y=%h v=%b sel=%0d required y=%h v=1 sel=%0d",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, exp_y, exp_sel);
            end
        end
    endtask

`ifdef CH_MASK_EN
    task automatic test_ch_mask();
        logic [2:0] seq_sel [9] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0};
        bus8.ch_mask = 8'b1010_0101;
        bus8.mode    = 1'b0;
        tick();
        bus8.mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_sel  = seq_sel[i];
            exp_y    = 4'(exp_sel) + 4'd1;
            exp_wrap = (i == 7);
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {exp_y, 1'b1, exp_sel, exp_wrap}) begin
                n_fail++;
                $display("FAIL mask_step%0d: got y=%h v=%b sel=%0d wrap=%b required y=%h v=1 sel=%0d wrap=%b",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap, exp_y, exp_sel, exp_wrap);
            end
        end
        bus8.ch_mask = 8'h00;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_run++;
            if ({bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap} !== {4'h1, 1'b0, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL mask_zero%0d: got y=%h v=%b sel=%0d wrap=%b required y=1 v=0 sel=0 wrap=0",
                         i, bus8.y, bus8.y_valid, bus8.cur_sel, bus8.wrap);
            end
        end
    endtask
`endif

    initial begin
        bus8.mode = 1'b0; bus8.en = 1'b0; bus8.sel = '0;
        bus6.mode = 1'b0; bus6.en = 1'b0; bus6.sel = '0;
        for (int k = 0; k < 8; k++) bus8.in_bus[k*4 +: 4] = 4'(k + 1);
        for (int k = 0; k < 6; k++) bus6.in_bus[k*4 +: 4] = 4'(k + 1);
`ifdef CH_MASK_EN
        bus8.ch_mask = '1;
        bus6.ch_mask = '1;
`endif
        test_reset_initial();
        test_direct();
        test_scan();
        test_pause();
        test_mode_switch();
        test_reset_mid_scan();
`ifdef CH_MASK_EN
        test_ch_mask();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
